uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter. Successor to the fixed 8-bit transmitter used in the UART loopback top.
- Adds configurable data width, parity mode and stop-bit count.
- Adds a write FIFO, so the host can queue several words without polling Tx_BUSY.
- Drives TxD for the existing receiver/synchronizer path and for external pins.

---
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 tb/tb_uart_tx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with configurable width, parity, stop bits and baud rate
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int PARITY = 1,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_FREQ = 50000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_BITS-1:0]         Tx_DATA,
  input  logic                         Tx_WR,
  input  logic                         Tx_EN,
  input  logic [2:0]                   baud_select,
  output logic                         TxD,
  output logic                         Tx_BUSY,
  output logic                         Tx_FULL,
  output logic [$clog2(FIFO_DEPTH):0]  Tx_COUNT,
  output logic                         Tx_OVERFLOW
);
  localparam int AW = $clog2(FIFO_DEPTH);
  function automatic int div_of(input int k);
    int b, d;
    b = k == 0 ? 300 : k == 1 ? 1200 : k == 2 ? 4800 : k == 3 ? 9600 :
        k == 4 ? 19200 : k == 5 ? 38400 : k == 6 ? 57600 : 115200;
    d = (CLK_FREQ + 8 * b) / (16 * b);
    return d < 1 ? 1 : d;
  endfunction
  localparam int PW = $clog2(16 * div_of(0) + 1);
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;
  logic [PW-1:0] per_tab [8];
  for (genvar k = 0; k < 8; k++) begin : g_tab
    assign per_tab[k] = PW'(16 * div_of(k));
  end
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count_n;
  state_t state, state_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic [PW-1:0] per, per_n, cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic par, par_n, pop, wr_ok, can_pop, tick, last_data, last_stop, txd_n;
  assign Tx_FULL = Tx_COUNT == (AW+1)'(FIFO_DEPTH);
  assign wr_ok = Tx_WR && !Tx_FULL;
  assign can_pop = Tx_EN && Tx_COUNT != '0;
  assign tick = cnt == per - 1'b1;
  assign last_data = idx == 4'(DATA_BITS - 1);
  assign last_stop = idx == 4'(STOP_BITS - 1);
  assign count_n = Tx_COUNT + (AW+1)'(wr_ok) - (AW+1)'(pop);
  always_comb begin
    state_n = state;
    sh_n = sh;
    per_n = per;
    idx_n = idx;
    pop = 1'b0;
    cnt_n = tick ? '0 : cnt + 1'b1;
    case (state)
      ST_IDLE: cnt_n = '0;
      ST_START: if (tick) state_n = ST_DATA;
      ST_DATA: if (tick) begin
        sh_n = sh >> 1;
        idx_n = last_data ? '0 : idx + 1'b1;
        if (last_data) state_n = PARITY != 0 ? ST_PAR : ST_STOP;
      end
      ST_PAR: if (tick) state_n = ST_STOP;
      ST_STOP: if (tick) begin
        idx_n = last_stop ? '0 : idx + 1'b1;
        if (last_stop) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    // a pop at the end of the last stop bit chains frames with no idle gap
    if (can_pop && (state == ST_IDLE || (state == ST_STOP && tick && last_stop))) begin
      pop = 1'b1;
      sh_n = mem[rptr];
      per_n = per_tab[baud_select];
      cnt_n = '0;
      state_n = ST_START;
    end
    par_n = pop ? (^mem[rptr]) ^ (PARITY == 2) : par;
    txd_n = state_n == ST_START ? 1'b0 : state_n == ST_DATA ? sh_n[0] : state_n == ST_PAR ? par_n : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sh <= '0;
      per <= '0;
      cnt <= '0;
      idx <= '0;
      par <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      Tx_COUNT <= '0;
      TxD <= 1'b1;
      Tx_BUSY <= 1'b0;
      Tx_OVERFLOW <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      per <= per_n;
      cnt <= cnt_n;
      idx <= idx_n;
      par <= par_n;
      wptr <= wptr + AW'(wr_ok);
      rptr <= rptr + AW'(pop);
      Tx_COUNT <= count_n;
      TxD <= txd_n;
      Tx_BUSY <= state_n != ST_IDLE || count_n != '0;
      Tx_OVERFLOW <= Tx_WR && Tx_FULL;
    end
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wptr] <= Tx_DATA;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized frame checks of uart_tx_fifo against a queue-based reference model
module tb_uart_tx_fifo;
  localparam int CF = 1843200;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] d1 = '0;
  logic wr1 = 1'b0, en1 = 1'b0;
  logic [2:0] baud1 = 3'd7;
  logic txd1, busy1, full1, ovf1;
  logic [3:0] cnt1;
  logic [6:0] d2 = '0;
  logic wr2 = 1'b0, en2 = 1'b0;
  logic [2:0] baud2 = 3'd7;
  logic txd2, busy2, full2, ovf2;
  logic [3:0] cnt2;
  int checks = 0, failures = 0;
  bit sel = 1'b0;
  logic txd_s, busy_s;
  logic [7:0] q[$];
  assign txd_s = sel ? txd2 : txd1;
  assign busy_s = sel ? busy2 : busy1;
  uart_tx_fifo #(.CLK_FREQ(CF)) u_dut1 (
    .clk(clk), .reset(reset), .Tx_DATA(d1), .Tx_WR(wr1), .Tx_EN(en1), .baud_select(baud1),
    .TxD(txd1), .Tx_BUSY(busy1), .Tx_FULL(full1), .Tx_COUNT(cnt1), .Tx_OVERFLOW(ovf1));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLK_FREQ(CF)) u_dut2 (
    .clk(clk), .reset(reset), .Tx_DATA(d2), .Tx_WR(wr2), .Tx_EN(en2), .baud_select(baud2),
    .TxD(txd2), .Tx_BUSY(busy2), .Tx_FULL(full2), .Tx_COUNT(cnt2), .Tx_OVERFLOW(ovf2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int per_of(input int baud);
    return 16 * ((CF + 8 * baud) / (16 * baud));
  endfunction
  task automatic push1(input logic [7:0] d);
    @(negedge clk);
    d1 = d;
    wr1 = 1'b1;
    @(negedge clk);
    wr1 = 1'b0;
    chk("overflow", ovf1, q.size() == 8);
    if (q.size() < 8) q.push_back(d);
  endtask
  task automatic push2(input logic [6:0] d);
    @(negedge clk);
    d2 = d;
    wr2 = 1'b1;
    @(negedge clk);
    wr2 = 1'b0;
  endtask
  task automatic wait_start(output int n);
    n = 0;
    @(negedge clk);
    while (txd_s !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("start_seen", 0, 1);
  endtask
  task automatic frame(input string tag, input int data, input int nb, input int pm, input int sb, input int per);
    bit b[$];
    int good, ones;
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      b.push_back(data[i]);
      ones += data[i];
    end
    if (pm != 0) b.push_back((ones % 2 == 1) ^ (pm == 2));
    for (int i = 0; i < sb; i++) b.push_back(1'b1);
    chk({tag, "_busy"}, busy_s, 1);
    foreach (b[j]) begin
      good = 0;
      for (int c = 0; c < per; c++) begin
        if (j > 0 || c > 0) @(negedge clk);
        good += int'(txd_s === b[j]);
      end
      chk($sformatf("%s_bit%0d", tag, j), good, per);
    end
  endtask
  task automatic end_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy_low"}, busy_s, 0);
    chk({tag, "_txd_idle"}, txd_s, 1);
  endtask
  task automatic count_low(input string tag, input int cycles);
    int z;
    z = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      z += int'(txd_s !== 1'b1);
    end
    chk(tag, z, 0);
  endtask
  initial begin
    int n;
    logic [7:0] w;
    logic [6:0] w2;
    repeat (2) @(negedge clk);
    chk("rst_txd", txd1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_full", full1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst2_txd", txd2, 1);
    chk("rst2_state", {busy2, full2, ovf2, cnt2}, 0);
    reset = 1'b0;
    en1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = i == 0 ? 8'hA5 : 8'($urandom);
      push1(w);
      wait_start(n);
      frame($sformatf("f1_%0d", i), q.pop_front(), 8, 1, 1, 16);
      end_idle("f1");
    end
    sel = 1'b1;
    en2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w2 = i == 0 ? 7'h13 : 7'($urandom);
      push2(w2);
      wait_start(n);
      frame($sformatf("f2_%0d", i), w2, 7, 2, 2, 16);
      end_idle("f2");
    end
    sel = 1'b0;
    en1 = 1'b0;
    for (int i = 0; i < 8; i++) push1(8'($urandom));
    chk("fill_count", cnt1, 8);
    chk("fill_full", full1, 1);
    chk("fill_busy", busy1, 1);
    push1(8'($urandom));
    @(negedge clk);
    chk("ovf_one_cycle", ovf1, 0);
    chk("ovf_count", cnt1, 8);
    count_low("en_low_idle", 50);
    en1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start(n);
      if (i > 0) chk("b2b_gap", n, 0);
      w = q.pop_front();
      chk("b2b_count", cnt1, q.size());
      if (i == 0) chk("b2b_full_drop", full1, 0);
      frame($sformatf("b2b_%0d", i), w, 8, 1, 1, 16);
    end
    end_idle("b2b");
    en1 = 1'b0;
    for (int i = 0; i < 3; i++) push1(8'($urandom));
    en1 = 1'b1;
    wait_start(n);
    void'(q.pop_front());
    repeat (16 + 40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_txd", txd1, 1);
    chk("midrst_count", cnt1, 0);
    chk("midrst_busy", busy1, 0);
    reset = 1'b0;
    q.delete();
    count_low("midrst_discard", 300);
    en1 = 1'b0;
    baud1 = 3'd7;
    push1(8'($urandom));
    push1(8'($urandom));
    en1 = 1'b1;
    wait_start(n);
    w = q.pop_front();
    fork
      frame("baud_a", w, 8, 1, 1, per_of(115200));
      begin
        repeat (50) @(negedge clk);
        baud1 = 3'd6;
      end
    join
    wait_start(n);
    chk("baud_gap", n, 0);
    frame("baud_b", q.pop_front(), 8, 1, 1, per_of(57600));
    end_idle("baud");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
